// File: rtl/ssd_text_scroller.sv
`default_nettype none
// ============================================================================
//  Module   : ssd_text_scroller
//  Purpose  : Front end for the 4-digit SSD scanner. Debounces and normalises
//             the raw drive command, then scrolls the 7-letter message
//             "drIVInG" (letter codes 0..6) across four digit slots while the
//             car moves. When stopped, the window sits at its home position.
//  Ports    : clk        - system clock
//             rst_n      - synchronous, active-low reset
//             drive_cmd  - raw command (10 fwd, 01 rev, 00/11 stop)
//             drive      - filtered, normalised command to the scanner
//             q0..q3     - letter codes, q0 leftmost .. q3 rightmost
//             step       - one-cycle pulse on each scroll step
//  Revision : 1.0 - initial release
// ============================================================================
module ssd_text_scroller #(
  parameter int SCROLL_DIV    = 50_000_000,  // cycles per scroll step, >= 2
  parameter int STABLE_CYCLES = 1000         // hold time to accept a command, >= 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] drive_cmd,
  output logic [1:0] drive,
  output logic [2:0] q0,
  output logic [2:0] q1,
  output logic [2:0] q2,
  output logic [2:0] q3,
  output logic       step
);

  localparam int DIV_W  = (SCROLL_DIV > 1)    ? $clog2(SCROLL_DIV)    : 1;
  localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  localparam logic [DIV_W-1:0]  C_DIV_MAX  = DIV_W'(SCROLL_DIV - 1);
  localparam logic [STAB_W-1:0] C_STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [2:0]        C_PTR_MAX  = 3'd6;

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_REV  = 2'b01,
    ST_FWD  = 2'b10
  } state_t;

  logic [1:0]        r_cand;
  logic [STAB_W-1:0] r_stab_cnt;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [2:0]        r_ptr;

  logic [1:0]        w_cmd_n;
  logic              w_accept;
  logic              w_direct_rev;
  state_t            w_state;
  logic [2:0]        w_ptr_next;
  logic [DIV_W-1:0]  w_div_next;
  logic              w_step_next;

  // Letter index of slot k for window start 'base', wrapped into 0..6.
  function automatic logic [2:0] wrap7(input logic [2:0] base, input logic [1:0] k);
    logic [3:0] sum;
    sum = {1'b0, base} + {2'b00, k};
    return (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];
  endfunction

  // 11 is an illegal "both directions" request; treat it as stop.
  assign w_cmd_n = (drive_cmd == 2'b11) ? 2'b00 : drive_cmd;

  // Candidate held long enough and differs from the current output.
  assign w_accept = (w_cmd_n == r_cand) && (r_cand != drive) && (r_stab_cnt == C_STAB_MAX);

  // FWD <-> REV without passing through stop: keep the window, restart timing.
  assign w_direct_rev = w_accept && (drive != 2'b00) && (r_cand != 2'b00);

  always_comb begin
    case (drive)
      2'b10:   w_state = ST_FWD;
      2'b01:   w_state = ST_REV;
      default: w_state = ST_STOP;
    endcase
  end

  // Next window position and divider; q outputs are derived from w_ptr_next
  // so they update on the same edge as the pointer.
  always_comb begin
    w_ptr_next  = r_ptr;
    w_div_next  = r_div_cnt;
    w_step_next = 1'b0;
    if (w_direct_rev) begin
      w_div_next = '0;
    end else begin
      case (w_state)
        ST_FWD, ST_REV: begin
          if (r_div_cnt == C_DIV_MAX) begin
            w_div_next  = '0;
            w_step_next = 1'b1;
            if (w_state == ST_FWD) begin
              w_ptr_next = (r_ptr == C_PTR_MAX) ? 3'd0 : r_ptr + 3'd1;
            end else begin
              w_ptr_next = (r_ptr == 3'd0) ? C_PTR_MAX : r_ptr - 3'd1;
            end
          end else begin
            w_div_next = r_div_cnt + 1'b1;
          end
        end
        default: begin
          w_ptr_next = 3'd0;
          w_div_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cand     <= 2'b00;
      r_stab_cnt <= '0;
      drive      <= 2'b00;
      r_div_cnt  <= '0;
      r_ptr      <= 3'd0;
      step       <= 1'b0;
      q0         <= 3'd0;
      q1         <= 3'd1;
      q2         <= 3'd2;
      q3         <= 3'd3;
    end else begin
      // Command filter
      if (w_cmd_n != r_cand) begin
        r_cand     <= w_cmd_n;
        r_stab_cnt <= '0;
      end else if (r_cand != drive) begin
        if (r_stab_cnt == C_STAB_MAX) begin
          drive      <= r_cand;
          r_stab_cnt <= '0;
        end else begin
          r_stab_cnt <= r_stab_cnt + 1'b1;
        end
      end else begin
        r_stab_cnt <= '0;
      end

      // Scroll state
      r_div_cnt <= w_div_next;
      r_ptr     <= w_ptr_next;
      step      <= w_step_next;
      q0        <= wrap7(w_ptr_next, 2'd0);
      q1        <= wrap7(w_ptr_next, 2'd1);
      q2        <= wrap7(w_ptr_next, 2'd2);
      q3        <= wrap7(w_ptr_next, 2'd3);
    end
  end

endmodule
`default_nettype wire
